ecc_err_logger: RTL and testbench
=================================

ECC_ERR_LOGGER -- requirements
Module: ecc_err_logger

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of logged bus address.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each saturating error counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port evt_valid_i  input  1  one decoded write beat (req & gnt & write) this cycle.
REQ-006 SHALL have port addr_i  input  ADDR_WIDTH  address of the beat.
REQ-007 SHALL have port syndrome_i  input  7  SECDED(39,32) syndrome from the decoder.
REQ-008 SHALL have port err_i  input  2  decoder error: bit0 correctable, bit1 uncorrectable.
REQ-009 SHALL have port ack_i  input  1  software acknowledge of the captured record.
REQ-010 SHALL have port clr_cnt_i  input  1  clear both counters.
REQ-011 SHALL have port irq_o  output  1  record pending, level.
REQ-012 SHALL have port log_addr_o  output  ADDR_WIDTH  captured address.
REQ-013 SHALL have port log_syndrome_o  output  7  captured syndrome.
REQ-014 SHALL have port log_uncorr_o  output  1  captured record is uncorrectable.
REQ-015 SHALL have port overflow_o  output  1  error seen while record pending (sticky).
REQ-016 SHALL have port corr_cnt_o  output  CNT_WIDTH  correctable-error count.
REQ-017 SHALL have port uncorr_cnt_o  output  CNT_WIDTH  uncorrectable-error count.

Function
REQ-018 SHALL qualify an error event as evt_valid_i=1 and err_i!=0; err_i=2'b11 SHALL be treated as uncorrectable only.
REQ-019 SHALL implement FSM states IDLE and CAPTURED; irq_o SHALL be 1 iff state is CAPTURED (registered, no combinational path from inputs).
REQ-020 IDLE + event: capture addr_i, syndrome_i, uncorr flag into log registers next edge, go CAPTURED; latency one cycle to irq_o.
REQ-021 CAPTURED + event, ack_i=0: set overflow_o; if record is correctable and event uncorrectable, recapture (priority upgrade); otherwise log registers hold.
REQ-022 CAPTURED + ack_i=1, no event: go IDLE, clear overflow_o; log registers hold last values.
REQ-023 CAPTURED + ack_i=1 + event same cycle: capture the new event, stay CAPTURED, overflow_o cleared.
REQ-024 ack_i in IDLE SHALL have no effect.
REQ-025 Each event SHALL increment exactly one counter (uncorr if err_i[1], else corr) by 1, saturating at 2^CNT_WIDTH-1 without wrap.
REQ-026 clr_cnt_i=1 SHALL zero both counters next edge; with simultaneous event, counter result SHALL be 1 for the event type, 0 for the other.
REQ-027 Events with evt_valid_i=0 SHALL be ignored regardless of err_i.

Reset
REQ-028 rst_ni=0 SHALL asynchronously force IDLE, irq_o=0, overflow_o=0, log_addr_o=0, log_syndrome_o=0, log_uncorr_o=0, both counters 0, including mid-CAPTURED.
REQ-029 First event after reset deassertion SHALL be handled as REQ-020 on the first active edge.

Verification
REQ-030 Single event err_i=01, addr 0x1000_0040, syndrome 0x25 -> next cycle irq_o=1, log_addr_o=0x1000_0040, log_syndrome_o=0x25, log_uncorr_o=0, corr_cnt_o=1.
REQ-031 Pending corr record then event err_i=10 at 0x2000_0000 -> record upgraded, log_uncorr_o=1, overflow_o=1, uncorr_cnt_o=1; further corr event leaves record unchanged.
REQ-032 ack_i with simultaneous event err_i=11 -> irq_o stays 1, new record captured uncorr, overflow_o=0, uncorr_cnt_o incremented.
REQ-033 CNT_WIDTH=4, 17 corr events -> corr_cnt_o=15 saturated; clr_cnt_i with event same cycle -> corr_cnt_o=1.
REQ-034 rst_ni asserted asynchronously between edges while CAPTURED -> all outputs 0 immediately, before next clock edge.
REQ-035 err_i=01 with evt_valid_i=0 for 10 cycles -> no irq, counters remain 0.

Source files
------------

// File: rtl/ecc_err_logger.sv
// rtl/ecc_err_logger.sv - ECC error capture register with pending interrupt, overflow flag and saturating counters
module ecc_err_logger #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  evt_valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [6:0]            syndrome_i,
  input  logic [1:0]            err_i,
  input  logic                  ack_i,
  input  logic                  clr_cnt_i,
  output logic                  irq_o,
  output logic [ADDR_WIDTH-1:0] log_addr_o,
  output logic [6:0]            log_syndrome_o,
  output logic                  log_uncorr_o,
  output logic                  overflow_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CAPTURED = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            state_q, state_d;
  logic                  ovf_q, ovf_d;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [6:0]            syn_q;
  logic                  uncorr_q;
  logic [CNT_WIDTH-1:0]  corr_q, corr_d, corr_base;
  logic [CNT_WIDTH-1:0]  uncorr_cnt_q, uncorr_cnt_d, uncorr_base;

  logic event_hit;
  logic event_uncorr;

  // An event needs a valid beat and a nonzero error code; bit1 wins when both bits are set.
  assign event_hit    = evt_valid_i & (|err_i);
  assign event_uncorr = err_i[1];

  // Record FSM: decides when to (re)capture and how the overflow flag evolves.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (event_hit) begin
          capture = 1'b1;
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        if (ack_i) begin
          // Acknowledge frees the record; a coincident event immediately refills it.
          ovf_d = 1'b0;
          if (event_hit) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (event_hit) begin
          // Record still owned by software: flag the loss, but let an
          // uncorrectable error displace a correctable one.
          ovf_d = 1'b1;
          if (!uncorr_q && event_uncorr) begin
            capture = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Counter next values: clear first, then count this cycle's event so clear+event yields one.
  always_comb begin
    corr_base    = clr_cnt_i ? '0 : corr_q;
    uncorr_base  = clr_cnt_i ? '0 : uncorr_cnt_q;
    corr_d       = corr_base;
    uncorr_cnt_d = uncorr_base;
    if (event_hit) begin
      if (event_uncorr) begin
        if (uncorr_base != CNT_MAX) begin
          uncorr_cnt_d = uncorr_base + CNT_ONE;
        end
      end else begin
        if (corr_base != CNT_MAX) begin
          corr_d = corr_base + CNT_ONE;
        end
      end
    end
  end

  // State, overflow and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ovf_q        <= 1'b0;
      corr_q       <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ovf_q        <= ovf_d;
      corr_q       <= corr_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  // Log registers load only on capture and otherwise hold, including after acknowledge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      syn_q    <= '0;
      uncorr_q <= 1'b0;
    end else if (capture) begin
      addr_q   <= addr_i;
      syn_q    <= syndrome_i;
      uncorr_q <= event_uncorr;
    end
  end

  assign irq_o          = (state_q == CAPTURED);
  assign overflow_o     = ovf_q;
  assign log_addr_o     = addr_q;
  assign log_syndrome_o = syn_q;
  assign log_uncorr_o   = uncorr_q;
  assign corr_cnt_o     = corr_q;
  assign uncorr_cnt_o   = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_err_logger.sv
// tb/tb_ecc_err_logger.sv - randomized self-checking bench for ecc_err_logger
module tb_ecc_err_logger;

  localparam int AW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          evt_valid_i;
  logic [AW-1:0] addr_i;
  logic [6:0]    syndrome_i;
  logic [1:0]    err_i;
  logic          ack_i;
  logic          clr_cnt_i;
  logic          irq_o;
  logic [AW-1:0] log_addr_o;
  logic [6:0]    log_syndrome_o;
  logic          log_uncorr_o;
  logic          overflow_o;
  logic [CW-1:0] corr_cnt_o;
  logic [CW-1:0] uncorr_cnt_o;

  int total = 0;
  int bad   = 0;

  // Reference model: a pending flag plus a record, with counters as plain integers.
  bit        m_pend;
  bit [31:0] m_addr;
  bit [6:0]  m_syn;
  bit        m_unc;
  bit        m_ovf;
  int        m_corr;
  int        m_ucnt;

  ecc_err_logger #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .evt_valid_i    (evt_valid_i),
    .addr_i         (addr_i),
    .syndrome_i     (syndrome_i),
    .err_i          (err_i),
    .ack_i          (ack_i),
    .clr_cnt_i      (clr_cnt_i),
    .irq_o          (irq_o),
    .log_addr_o     (log_addr_o),
    .log_syndrome_o (log_syndrome_o),
    .log_uncorr_o   (log_uncorr_o),
    .overflow_o     (overflow_o),
    .corr_cnt_o     (corr_cnt_o),
    .uncorr_cnt_o   (uncorr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    m_pend = 0; m_addr = 0; m_syn = 0; m_unc = 0; m_ovf = 0; m_corr = 0; m_ucnt = 0;
  endfunction

  function automatic void model_step(bit v, bit [31:0] a, bit [6:0] s, bit [1:0] e, bit k, bit c);
    bit ev;
    bit u;
    ev = v && (e != 2'b00);
    u  = e[1];
    if (m_pend) begin
      if (k) begin
        m_ovf = 0;
        if (ev) begin m_addr = a; m_syn = s; m_unc = u; end
        else m_pend = 0;
      end else if (ev) begin
        m_ovf = 1;
        if (!m_unc && u) begin m_addr = a; m_syn = s; m_unc = u; end
      end
    end else if (ev) begin
      m_pend = 1; m_addr = a; m_syn = s; m_unc = u;
    end
    if (c) begin m_corr = 0; m_ucnt = 0; end
    if (ev) begin
      if (u) m_ucnt = (m_ucnt + 1 > CMAX) ? CMAX : m_ucnt + 1;
      else   m_corr = (m_corr + 1 > CMAX) ? CMAX : m_corr + 1;
    end
  endfunction

  // Applies one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic drive(input logic v, input logic [31:0] a, input logic [6:0] s,
                       input logic [1:0] e, input logic k, input logic c);
    evt_valid_i = v; addr_i = a; syndrome_i = s; err_i = e; ack_i = k; clr_cnt_i = c;
    model_step(v, a, s, e, k, c);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    evt_valid_i = 0; addr_i = 0; syndrome_i = 0; err_i = 0; ack_i = 0; clr_cnt_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({irq_o, overflow_o, log_uncorr_o, log_addr_o, log_syndrome_o, corr_cnt_o, uncorr_cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got irq=%b ovf=%b unc=%b addr=%h syn=%h cc=%0d uc=%0d, want all 0",
               irq_o, overflow_o, log_uncorr_o, log_addr_o, log_syndrome_o, corr_cnt_o, uncorr_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 10; i++) drive(1'b0, 32'h0000_1234, 7'h33, 2'b01, 1'b0, 1'b0);
    total++;
    if (irq_o !== 1'b0 || corr_cnt_o !== '0 || uncorr_cnt_o !== '0) begin
      bad++;
      $display("FAIL invalid_ignored: got irq=%b cc=%0d uc=%0d, want 0 0 0", irq_o, corr_cnt_o, uncorr_cnt_o);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 32'h1000_0040, 7'h25, 2'b01, 1'b0, 1'b0);
    total++;
    if (irq_o !== 1'b1 || log_addr_o !== 32'h1000_0040 || log_syndrome_o !== 7'h25 ||
        log_uncorr_o !== 1'b0 || corr_cnt_o !== 4'd1 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL single_event: got irq=%b addr=%h syn=%h unc=%b cc=%0d ovf=%b, want 1 10000040 25 0 1 0",
               irq_o, log_addr_o, log_syndrome_o, log_uncorr_o, corr_cnt_o, overflow_o);
    end
  endtask

  task automatic test_upgrade();
    drive(1'b1, 32'h2000_0000, 7'h11, 2'b10, 1'b0, 1'b0);
    total++;
    if (log_addr_o !== 32'h2000_0000 || log_syndrome_o !== 7'h11 || log_uncorr_o !== 1'b1 ||
        overflow_o !== 1'b1 || uncorr_cnt_o !== 4'd1 || irq_o !== 1'b1) begin
      bad++;
      $display("FAIL upgrade: got addr=%h syn=%h unc=%b ovf=%b uc=%0d irq=%b, want 20000000 11 1 1 1 1",
               log_addr_o, log_syndrome_o, log_uncorr_o, overflow_o, uncorr_cnt_o, irq_o);
    end
    drive(1'b1, 32'h3000_0000, 7'h05, 2'b01, 1'b0, 1'b0);
    total++;
    if (log_addr_o !== 32'h2000_0000 || log_syndrome_o !== 7'h11 || log_uncorr_o !== 1'b1 ||
        corr_cnt_o !== 4'd2 || overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL upgrade_hold: got addr=%h syn=%h unc=%b cc=%0d ovf=%b, want 20000000 11 1 2 1",
               log_addr_o, log_syndrome_o, log_uncorr_o, corr_cnt_o, overflow_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h4000_0000, 7'h7f, 2'b11, 1'b1, 1'b0);
    total++;
    if (irq_o !== 1'b1 || log_addr_o !== 32'h4000_0000 || log_syndrome_o !== 7'h7f ||
        log_uncorr_o !== 1'b1 || overflow_o !== 1'b0 || uncorr_cnt_o !== 4'd2 || corr_cnt_o !== 4'd2) begin
      bad++;
      $display("FAIL ack_with_event: got irq=%b addr=%h syn=%h unc=%b ovf=%b uc=%0d cc=%0d, want 1 40000000 7f 1 0 2 2",
               irq_o, log_addr_o, log_syndrome_o, log_uncorr_o, overflow_o, uncorr_cnt_o, corr_cnt_o);
    end
    drive(1'b0, 32'h0, 7'h0, 2'b00, 1'b1, 1'b0);
    total++;
    if (irq_o !== 1'b0 || overflow_o !== 1'b0 || log_addr_o !== 32'h4000_0000 || log_uncorr_o !== 1'b1) begin
      bad++;
      $display("FAIL ack_release: got irq=%b ovf=%b addr=%h unc=%b, want 0 0 40000000 1",
               irq_o, overflow_o, log_addr_o, log_uncorr_o);
    end
    drive(1'b0, 32'h0, 7'h0, 2'b00, 1'b1, 1'b0);
    total++;
    if (irq_o !== 1'b0 || log_addr_o !== 32'h4000_0000) begin
      bad++;
      $display("FAIL ack_in_idle: got irq=%b addr=%h, want 0 40000000", irq_o, log_addr_o);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 17; i++) drive(1'b1, 32'h5000_0000 + i, 7'(i), 2'b01, 1'b0, 1'b0);
    total++;
    if (corr_cnt_o !== 4'd15) begin
      bad++;
      $display("FAIL corr_saturate: got %0d want 15", corr_cnt_o);
    end
    drive(1'b1, 32'h6000_0000, 7'h01, 2'b01, 1'b0, 1'b1);
    total++;
    if (corr_cnt_o !== 4'd1 || uncorr_cnt_o !== 4'd0) begin
      bad++;
      $display("FAIL clr_with_event: got cc=%0d uc=%0d want 1 0", corr_cnt_o, uncorr_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h7000_0000, 7'h2a, 2'b10, 1'b0, 1'b0);
    idle_inputs();
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    total++;
    if ({irq_o, overflow_o, log_uncorr_o, log_addr_o, log_syndrome_o, corr_cnt_o, uncorr_cnt_o} !== '0) begin
      bad++;
      $display("FAIL async_reset: got irq=%b ovf=%b unc=%b addr=%h syn=%h cc=%0d uc=%0d, want all 0",
               irq_o, overflow_o, log_uncorr_o, log_addr_o, log_syndrome_o, corr_cnt_o, uncorr_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, 32'h0bad_cafe, 7'h3c, 2'b01, 1'b0, 1'b0);
    total++;
    if (irq_o !== 1'b1 || log_addr_o !== 32'h0bad_cafe || log_syndrome_o !== 7'h3c || corr_cnt_o !== 4'd1) begin
      bad++;
      $display("FAIL first_after_reset: got irq=%b addr=%h syn=%h cc=%0d, want 1 0badcafe 3c 1",
               irq_o, log_addr_o, log_syndrome_o, corr_cnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, 7'($urandom), 2'($urandom), ($urandom % 4) == 0, ($urandom % 16) == 0);
      total++;
      if (irq_o !== m_pend || overflow_o !== m_ovf || log_addr_o !== m_addr || log_syndrome_o !== m_syn ||
          log_uncorr_o !== m_unc || corr_cnt_o !== CW'(m_corr) || uncorr_cnt_o !== CW'(m_ucnt)) begin
        bad++;
        $display("FAIL random_%0d: got irq=%b ovf=%b addr=%h syn=%h unc=%b cc=%0d uc=%0d, want %b %b %h %h %b %0d %0d",
                 i, irq_o, overflow_o, log_addr_o, log_syndrome_o, log_uncorr_o, corr_cnt_o, uncorr_cnt_o,
                 m_pend, m_ovf, m_addr, m_syn, m_unc, m_corr, m_ucnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_single();
    test_upgrade();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
